// File: rtl/tx_arbiter_if.sv
// Handshake bundle between the ADS/MPR requesters, the TX arbiter and the UART TX controller.
interface tx_arbiter_if;
  logic [31:0] i_ADS_DATA;
  logic        i_ADS_VALID;
  logic        o_ADS_READY;
  logic [31:0] i_MPR_DATA;
  logic        i_MPR_VALID;
  logic        o_MPR_READY;
  logic [31:0] o_UART_DATA_TX;
  logic        o_UART_DATA_TX_VALID;
  logic        i_UART_DATA_TX_READY;
  logic [1:0]  o_GRANT;
  logic [7:0]  o_DROP_CNT;

  modport slave (
    input  i_ADS_DATA, i_ADS_VALID, i_MPR_DATA, i_MPR_VALID, i_UART_DATA_TX_READY,
    output o_ADS_READY, o_MPR_READY, o_UART_DATA_TX, o_UART_DATA_TX_VALID, o_GRANT, o_DROP_CNT
  );

  modport master (
    output i_ADS_DATA, i_ADS_VALID, i_MPR_DATA, i_MPR_VALID, i_UART_DATA_TX_READY,
    input  o_ADS_READY, o_MPR_READY, o_UART_DATA_TX, o_UART_DATA_TX_VALID, o_GRANT, o_DROP_CNT
  );
endinterface

// File: rtl/tx_arbiter.sv
// Arbitrates ADS and MPR frames onto one UART TX stream; one-entry holding buffer per requester,
// header screening with a saturating drop counter, and fully registered outputs.
module tx_arbiter #(
  parameter bit PRIORITY_MODE = 1'b0
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_WAIT_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] ads_buf_q, mpr_buf_q;
  logic        ads_full_q, mpr_full_q;
  logic        live_q;
  logic        last_ads_q;
  logic [31:0] tx_data_q;
  logic        tx_vld_q;
  logic [1:0]  grant_q;
  logic [7:0]  drop_q;

  logic        ads_rdy, mpr_rdy, ads_ld, mpr_ld;
  logic        sel_mpr, sel_legal;
  logic [7:0]  sel_hdr;
  logic        launch, drop, retire, done;
  logic        ads_clr, mpr_clr;

  // READY stays low until the first edge after reset so requesters never load during reset
  assign ads_rdy = live_q & ~ads_full_q;
  assign mpr_rdy = live_q & ~mpr_full_q;
  assign ads_ld  = bus.i_ADS_VALID & ads_rdy;
  assign mpr_ld  = bus.i_MPR_VALID & mpr_rdy;

  always_comb begin
    sel_mpr = mpr_full_q;
    if (ads_full_q && mpr_full_q)
      sel_mpr = (PRIORITY_MODE == 1'b0) ? last_ads_q : 1'b0;
    sel_hdr   = sel_mpr ? mpr_buf_q[31:24] : ads_buf_q[31:24];
    sel_legal = sel_mpr ? (sel_hdr == 8'hBB || sel_hdr == 8'h6D)
                        : (sel_hdr == 8'hAA || sel_hdr == 8'h61);
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    drop    = 1'b0;
    retire  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ads_full_q || mpr_full_q) begin
          if (sel_legal) begin
            launch  = 1'b1;
            state_d = ST_GRANT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_GRANT: begin
        if (bus.i_UART_DATA_TX_READY) begin
          retire  = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // downstream drops READY on acceptance, so its return marks send completion
        if (bus.i_UART_DATA_TX_READY) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ads_clr = (drop & ~sel_mpr) | (retire & grant_q[0]);
  assign mpr_clr = (drop &  sel_mpr) | (retire & grant_q[1]);

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      live_q     <= 1'b0;
      ads_buf_q  <= '0;
      mpr_buf_q  <= '0;
      ads_full_q <= 1'b0;
      mpr_full_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (ads_ld) begin
        ads_buf_q  <= bus.i_ADS_DATA;
        ads_full_q <= 1'b1;
      end else if (ads_clr) begin
        ads_full_q <= 1'b0;
      end
      if (mpr_ld) begin
        mpr_buf_q  <= bus.i_MPR_DATA;
        mpr_full_q <= 1'b1;
      end else if (mpr_clr) begin
        mpr_full_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
      grant_q    <= 2'b00;
      last_ads_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (launch) begin
        tx_data_q <= sel_mpr ? mpr_buf_q : ads_buf_q;
        tx_vld_q  <= 1'b1;
        grant_q   <= sel_mpr ? 2'b10 : 2'b01;
      end
      if (retire) begin
        tx_vld_q   <= 1'b0;
        last_ads_q <= grant_q[0];
      end
      if (done)
        grant_q <= 2'b00;
      if (drop && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.o_ADS_READY          = ads_rdy;
  assign bus.o_MPR_READY          = mpr_rdy;
  assign bus.o_UART_DATA_TX       = tx_data_q;
  assign bus.o_UART_DATA_TX_VALID = tx_vld_q;
  assign bus.o_GRANT              = grant_q;
  assign bus.o_DROP_CNT           = drop_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed-vector bench for tx_arbiter: round-robin DUT driven directly, fixed-priority DUT
// mirrors the same requester inputs with its own always-ready downstream.
module tb_tx_arbiter;
  logic i_CLK = 1'b0;
  logic i_RST;
  logic rdy1;

  tx_arbiter_if bus();
  tx_arbiter_if bus1();

  assign bus1.i_ADS_DATA           = bus.i_ADS_DATA;
  assign bus1.i_ADS_VALID          = bus.i_ADS_VALID;
  assign bus1.i_MPR_DATA           = bus.i_MPR_DATA;
  assign bus1.i_MPR_VALID          = bus.i_MPR_VALID;
  assign bus1.i_UART_DATA_TX_READY = rdy1;

  tx_arbiter #(.PRIORITY_MODE(1'b0)) dut0 (.i_CLK(i_CLK), .i_RST(i_RST), .bus(bus));
  tx_arbiter #(.PRIORITY_MODE(1'b1)) dut1 (.i_CLK(i_CLK), .i_RST(i_RST), .bus(bus1));

  always #5 i_CLK = ~i_CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  // frames accepted downstream, one queue per DUT
  always @(posedge i_CLK) begin
    if (!i_RST && bus.o_UART_DATA_TX_VALID && bus.i_UART_DATA_TX_READY)
      q0.push_back(bus.o_UART_DATA_TX);
    if (!i_RST && bus1.o_UART_DATA_TX_VALID && rdy1)
      q1.push_back(bus1.o_UART_DATA_TX);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_CLK);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_vld"},   32'(bus.o_UART_DATA_TX_VALID), 32'd0);
    chk({tag, "_data"},  bus.o_UART_DATA_TX,            32'd0);
    chk({tag, "_grant"}, 32'(bus.o_GRANT),              32'd0);
    chk({tag, "_drop"},  32'(bus.o_DROP_CNT),           32'd0);
    chk({tag, "_adsr"},  32'(bus.o_ADS_READY),          32'd0);
    chk({tag, "_mprr"},  32'(bus.o_MPR_READY),          32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int prev;
    i_RST = 1'b1;
    rdy1  = 1'b1;
    bus.i_ADS_DATA = '0; bus.i_ADS_VALID = 1'b0;
    bus.i_MPR_DATA = '0; bus.i_MPR_VALID = 1'b0;
    bus.i_UART_DATA_TX_READY = 1'b1;
    cyc(2);
    chk_rst("rst");
    i_RST = 1'b0;
    cyc(1);
    chk("rel_adsr", 32'(bus.o_ADS_READY), 32'd1);
    chk("rel_mprr", 32'(bus.o_MPR_READY), 32'd1);

    // single legal ADS frame, downstream always ready
    bus.i_ADS_DATA = 32'hAA123456; bus.i_ADS_VALID = 1'b1;
    cyc(1);
    bus.i_ADS_VALID = 1'b0;
    chk("t1_adsr_busy", 32'(bus.o_ADS_READY),          32'd0);
    chk("t1_vld_early", 32'(bus.o_UART_DATA_TX_VALID), 32'd0);
    cyc(1);
    chk("t1_vld",   32'(bus.o_UART_DATA_TX_VALID), 32'd1);
    chk("t1_data",  bus.o_UART_DATA_TX,            32'hAA123456);
    chk("t1_grant", 32'(bus.o_GRANT),              32'd1);
    cyc(1);
    chk("t1_vld_clr",    32'(bus.o_UART_DATA_TX_VALID), 32'd0);
    chk("t1_grant_wait", 32'(bus.o_GRANT),              32'd1);
    chk("t1_adsr_back",  32'(bus.o_ADS_READY),          32'd1);
    cyc(1);
    chk("t1_grant_none", 32'(bus.o_GRANT), 32'd0);

    // illegal MPR header, then saturation of the drop counter
    bus.i_MPR_DATA = 32'h12345678; bus.i_MPR_VALID = 1'b1;
    cyc(1);
    bus.i_MPR_VALID = 1'b0;
    chk("t2_mprr_busy", 32'(bus.o_MPR_READY), 32'd0);
    cyc(1);
    chk("t2_drop1", 32'(bus.o_DROP_CNT),           32'd1);
    chk("t2_mprr",  32'(bus.o_MPR_READY),          32'd1);
    chk("t2_grant", 32'(bus.o_GRANT),              32'd0);
    chk("t2_vld",   32'(bus.o_UART_DATA_TX_VALID), 32'd0);
    bus.i_MPR_VALID = 1'b1;
    cyc(700);
    bus.i_MPR_VALID = 1'b0;
    cyc(2);
    chk("t2_drop_sat", 32'(bus.o_DROP_CNT), 32'hFF);

    // reset clears the counter; then round-robin vs fixed priority with busy downstream
    i_RST = 1'b1;
    cyc(1);
    chk("t3_rst_drop", 32'(bus.o_DROP_CNT), 32'd0);
    chk("t3_rst_vld",  32'(bus.o_UART_DATA_TX_VALID), 32'd0);
    i_RST = 1'b0;
    cyc(1);
    q0.delete(); q1.delete();
    bus.i_ADS_DATA = 32'hAA000001; bus.i_ADS_VALID = 1'b1;
    bus.i_MPR_DATA = 32'hBB000002; bus.i_MPR_VALID = 1'b1;
    busy = 0; prev = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (q0.size() > prev) begin
        prev = q0.size();
        bus.i_UART_DATA_TX_READY = 1'b0;
        busy = 3;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) bus.i_UART_DATA_TX_READY = 1'b1;
      end
    end
    bus.i_ADS_VALID = 1'b0; bus.i_MPR_VALID = 1'b0;
    bus.i_UART_DATA_TX_READY = 1'b1;
    cyc(20);
    chk("t3_rr_cnt", 32'(q0.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_rr_ord%0d", i), (i < q0.size()) ? q0[i] : 32'hX,
          (i % 2 == 0) ? 32'hAA000001 : 32'hBB000002);
    chk("t3_pr_cnt", 32'(q1.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t3_pr_ads%0d", i), (i < q1.size()) ? q1[i] : 32'hX, 32'hAA000001);

    // downstream stalled for 50 cycles
    q0.delete();
    bus.i_UART_DATA_TX_READY = 1'b0;
    bus.i_ADS_DATA = 32'h61ABCDEF; bus.i_ADS_VALID = 1'b1;
    cyc(1);
    bus.i_ADS_VALID = 1'b0;
    cyc(1);
    for (int i = 0; i < 50; i++) begin
      chk("t4_stall_vld",  32'(bus.o_UART_DATA_TX_VALID), 32'd1);
      chk("t4_stall_data", bus.o_UART_DATA_TX,            32'h61ABCDEF);
      cyc(1);
    end
    bus.i_UART_DATA_TX_READY = 1'b1;
    cyc(4);
    chk("t4_one_xfer",  32'(q0.size()), 32'd1);
    chk("t4_xfer_data", (q0.size() > 0) ? q0[0] : 32'hX, 32'h61ABCDEF);
    chk("t4_vld_clr",   32'(bus.o_UART_DATA_TX_VALID), 32'd0);

    // offer coinciding with the buffer clearing edge is not taken until the next edge
    q0.delete();
    bus.i_UART_DATA_TX_READY = 1'b0;
    bus.i_ADS_DATA = 32'hAA0000A5; bus.i_ADS_VALID = 1'b1;
    cyc(1);
    bus.i_ADS_VALID = 1'b0;
    cyc(1);
    chk("t5_held", 32'(bus.o_UART_DATA_TX_VALID), 32'd1);
    bus.i_ADS_DATA = 32'hAA0000B6; bus.i_ADS_VALID = 1'b1;
    bus.i_UART_DATA_TX_READY = 1'b1;
    cyc(1);
    chk("t5_not_taken", 32'(bus.o_ADS_READY), 32'd1);
    cyc(1);
    bus.i_ADS_VALID = 1'b0;
    chk("t5_taken", 32'(bus.o_ADS_READY), 32'd0);
    cyc(6);
    chk("t5_cnt",    32'(q0.size()), 32'd2);
    chk("t5_first",  (q0.size() > 0) ? q0[0] : 32'hX, 32'hAA0000A5);
    chk("t5_second", (q0.size() > 1) ? q0[1] : 32'hX, 32'hAA0000B6);

    // reset while a frame is granted and both buffers are full
    q0.delete();
    bus.i_UART_DATA_TX_READY = 1'b0;
    bus.i_ADS_DATA = 32'h61000011; bus.i_ADS_VALID = 1'b1;
    bus.i_MPR_DATA = 32'h6D000022; bus.i_MPR_VALID = 1'b1;
    cyc(1);
    bus.i_ADS_VALID = 1'b0; bus.i_MPR_VALID = 1'b0;
    cyc(2);
    chk("t6_pre_grant", 32'(bus.o_GRANT), 32'd2);
    i_RST = 1'b1;
    #1;
    chk_rst("t6_rst");
    cyc(1);
    i_RST = 1'b0;
    bus.i_UART_DATA_TX_READY = 1'b1;
    cyc(20);
    chk("t6_silent",    32'(q0.size()),                32'd0);
    chk("t6_silent_vld", 32'(bus.o_UART_DATA_TX_VALID), 32'd0);
    bus.i_ADS_DATA = 32'hAA0000C1; bus.i_ADS_VALID = 1'b1;
    bus.i_MPR_DATA = 32'hBB0000C2; bus.i_MPR_VALID = 1'b1;
    cyc(1);
    bus.i_ADS_VALID = 1'b0; bus.i_MPR_VALID = 1'b0;
    cyc(1);
    chk("t6_ads_first", 32'(bus.o_GRANT),    32'd1);
    chk("t6_ads_data",  bus.o_UART_DATA_TX, 32'hAA0000C1);
    cyc(8);
    chk("t6_cnt",  32'(q0.size()), 32'd2);
    chk("t6_mpr",  (q0.size() > 1) ? q0[1] : 32'hX, 32'hBB0000C2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter PRIORITY_MODE, default 0; 0 = round-robin between ADS and MPR, 1 = fixed priority with ADS winning.
REQ-002 Reset i_RST is asynchronous and active-high; clock i_CLK.
REQ-003 i_CLK  input  1  system clock; all state updates on rising edge.
REQ-004 i_RST  input  1  asynchronous active-high reset.
REQ-005 i_ADS_DATA  input  32  ADS frame; [31:24] header, expected 0xAA or 0x61.
REQ-006 i_ADS_VALID  input  1  ADS frame offered.
REQ-007 o_ADS_READY  output  1  ADS holding buffer empty.
REQ-008 i_MPR_DATA  input  32  MPR frame; [31:24] header, expected 0xBB or 0x6D.
REQ-009 i_MPR_VALID  input  1  MPR frame offered.
REQ-010 o_MPR_READY  output  1  MPR holding buffer empty.
REQ-011 o_UART_DATA_TX  output  32  frame driven to the UART TX controller.
REQ-012 o_UART_DATA_TX_VALID  output  1  frame valid toward the UART TX controller.
REQ-013 i_UART_DATA_TX_READY  input  1  UART TX controller idle and able to accept.
REQ-014 o_GRANT  output  2  current owner; 01 = ADS, 10 = MPR, 00 = none.
REQ-015 o_DROP_CNT  output  8  count of frames discarded for an illegal header.

Function
REQ-016 Each requester SHALL have a one-entry 32-bit holding buffer; transfer occurs on an edge where VALID and READY are both 1; READY = buffer empty, with no bypass.
REQ-017 A freed buffer SHALL assert READY in the cycle after it frees; a buffer never loads and clears on the same edge.
REQ-018 FSM states SHALL be ST_IDLE, ST_GRANT and ST_WAIT_DONE.
REQ-019 ST_IDLE with no full buffer: SHALL remain in ST_IDLE, with o_UART_DATA_TX_VALID=0 and o_GRANT=00.
REQ-020 ST_IDLE with one or more full buffers: SHALL select a winner per REQ-021; on a legal header, SHALL load o_UART_DATA_TX, set o_UART_DATA_TX_VALID=1, set o_GRANT, and go to ST_GRANT.
REQ-021 Selection rule:
- Only one buffer full: that buffer wins.
- Both full, PRIORITY_MODE=0: the requester not granted last wins; after reset, ADS wins first.
- Both full, PRIORITY_MODE=1: ADS wins.
REQ-022 Illegal selected header (not one of 0xAA/0x61 for ADS, 0xBB/0x6D for MPR):
- Clear that buffer and increment o_DROP_CNT, saturating at 0xFF.
- Do not update the last-grant pointer; remain in ST_IDLE.
- The other buffer is evaluated on the next cycle.
REQ-023 ST_GRANT: o_UART_DATA_TX and o_UART_DATA_TX_VALID SHALL be held stable until an edge with i_UART_DATA_TX_READY=1.
REQ-024 On that edge the arbiter SHALL:
- clear VALID;
- clear the owner's buffer;
- record the owner as last granted;
- go to ST_WAIT_DONE.
REQ-025 ST_WAIT_DONE: o_GRANT SHALL hold the owner; the FSM returns to ST_IDLE on the first edge sampling i_UART_DATA_TX_READY=1, then o_GRANT=00.
- The downstream drops READY on the acceptance edge, so this edge marks frame-send completion.
REQ-026 Latency: requester accept at edge E0 SHALL give o_UART_DATA_TX_VALID=1 after edge E1 if the FSM is in ST_IDLE at E0.
REQ-027 Requesters SHALL keep loading their empty buffers in every state; only one frame is outstanding downstream at any time.
REQ-028 Outputs SHALL be registered, with no combinational path from i_UART_DATA_TX_READY to any output.

Reset
REQ-029 Asserting i_RST at any time, including mid-frame, SHALL:
- force ST_IDLE and empty both buffers;
- drive o_UART_DATA_TX=0, o_UART_DATA_TX_VALID=0, o_GRANT=00, o_DROP_CNT=0;
- reset the last-grant pointer so ADS wins next.
REQ-030 o_ADS_READY and o_MPR_READY SHALL be 0 during reset and 1 from the first edge after release.

Verification
REQ-031 Single ADS frame 0xAA123456, ready=1 → VALID one edge after accept, data 0xAA123456; o_GRANT 01 through ST_WAIT_DONE; o_ADS_READY returns to 1.
REQ-032 Both buffers full (0xAA000001, 0xBB000002), round-robin, downstream modelled as uart_controller → order ADS, MPR, ADS, MPR with both refilled continuously; with PRIORITY_MODE=1 and ADS always refilled, only ADS is sent.
REQ-033 MPR frame 0x12345678 → not granted, o_DROP_CNT=1, o_MPR_READY=1 on the next cycle; 300 illegal frames → o_DROP_CNT saturates at 0xFF.
REQ-034 Downstream ready held 0 for 50 cycles with ADS pending → VALID and data stable for all 50 cycles; exactly one transfer once ready rises.
REQ-035 i_RST pulsed while in ST_GRANT with both buffers full → all outputs at reset values; afterwards no frame is emitted until requesters re-offer.
REQ-036 ADS offers a frame on the same edge its buffer clears → not accepted that edge; accepted on the following edge.
